// File: rtl/xspi_pkg.sv
// Shared definitions for the xSPI slave: FSM states, header layout,
// lane-mode constants and the lane output-enable helper.
package xspi_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_DUMMY,
      S_WDATA,
      S_RDATA
   } state_t;

   // Header byte: bit 7 selects write (1) or read (0),
   // low ADDR_W bits carry the start address.
   localparam int HDR_RW_BIT = 7;

   localparam int LANE_SINGLE = 1;
   localparam int LANE_DUAL   = 2;
   localparam int LANE_QUAD   = 4;

   // In single-lane mode data leaves on sdio[1] (classic MISO).
   localparam int SINGLE_OUT_LANE = 1;

   function automatic logic [3:0] lane_mask(input int lanes);
      if (lanes == LANE_SINGLE) return 4'b0010;
      if (lanes == LANE_DUAL)   return 4'b0011;
      return 4'b1111;
   endfunction

endpackage

// File: rtl/xspi_sync.sv
// Two-flop synchronizer with rise/fall edge detect for sck or nss.
// Ports: clk, reset_n, din (async) -> rise, fall (one clk pulses).
module xspi_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic rise,
   output logic fall
);

   // sr[0], sr[1] form the synchronizer; sr[2] is the history bit.
   // Resetting to 0 means a low nss at reset release gives no falling
   // edge, so a transaction already in flight is never picked up.
   logic [2:0] sr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sr <= '0;
      else          sr <= {sr[1:0], din};
   end

   assign rise = sr[1] & ~sr[2];
   assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/xspi_slave.sv
// Multi-lane SPI slave bridging serial transactions to a byte CSR bus.
// Ports: clk/reset_n, sck/nss/sdio_* serial side, csr_* bus, overrun flag.
module xspi_slave
   import xspi_pkg::*;
#(
   parameter int LANES    = 4,
   parameter int ADDR_W   = 5,
   parameter int DUMMY    = 2,
   parameter int AUTO_INC = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sck,
   input  logic              nss,
   input  logic [3:0]        sdio_i,
   output logic [3:0]        sdio_o,
   output logic [3:0]        sdio_oe,
   output logic              chip_select,
   output logic [ADDR_W-1:0] csr_address,
   output logic              csr_read,
   output logic              csr_write,
   input  logic [7:0]        csr_readdata,
   output logic [7:0]        csr_writedata,
   output logic              overrun
);

   localparam int              EDGES = 8 / LANES;
   localparam logic [2:0]      LAST  = 3'(EDGES - 1);
   localparam logic [3:0]      DLAST = 4'(DUMMY - 1);
   localparam logic [ADDR_W-1:0] INC = ADDR_W'(AUTO_INC);

   logic sck_rise, sck_fall;
   logic nss_rise, nss_fall;

   xspi_sync u_sck (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (sck),
      .rise    (sck_rise),
      .fall    (sck_fall)
   );

   xspi_sync u_nss (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (nss),
      .rise    (nss_rise),
      .fall    (nss_fall)
   );

   state_t           state;
   logic [2:0]       bcnt;
   logic [2:0]       ocnt;
   logic [3:0]       dcnt;
   logic [7-LANES:0] sh_in;
   logic [7:0]       out_sh;
   logic [7:0]       pbuf;
   logic             pvalid;
   logic             rd_wait;
   logic [7:0]       byte_in;

   // Byte as it stands once the current rising edge is shifted in.
   assign byte_in = {sh_in, sdio_i[LANES-1:0]};

   function automatic logic [3:0] place(input logic [LANES-1:0] v);
      logic [3:0] o;
      o = '0;
      if (LANES == LANE_SINGLE) o[SINGLE_OUT_LANE] = v[0];
      else                      o[LANES-1:0] = v;
      return o;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         bcnt          <= '0;
         ocnt          <= '0;
         dcnt          <= '0;
         sh_in         <= '0;
         out_sh        <= '0;
         pbuf          <= '0;
         pvalid        <= 1'b0;
         rd_wait       <= 1'b0;
         sdio_o        <= '0;
         sdio_oe       <= '0;
         chip_select   <= 1'b0;
         csr_address   <= '0;
         csr_read      <= 1'b0;
         csr_write     <= 1'b0;
         csr_writedata <= '0;
         overrun       <= 1'b0;
      end else begin
         csr_read  <= 1'b0;
         csr_write <= 1'b0;
         // Read data arrives the cycle after the strobe.
         rd_wait   <= csr_read;
         if (rd_wait) begin
            pbuf   <= csr_readdata;
            pvalid <= 1'b1;
         end
         // Write address advances right after its strobe.
         if (csr_write) csr_address <= csr_address + INC;

         if (nss_rise) begin
            state       <= S_IDLE;
            chip_select <= 1'b0;
            sdio_oe     <= '0;
            sdio_o      <= '0;
            pvalid      <= 1'b0;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (nss_fall) begin
                     state       <= S_HDR;
                     chip_select <= 1'b1;
                     overrun     <= 1'b0;
                     bcnt        <= '0;
                  end
               end
               S_HDR: begin
                  if (sck_rise) begin
                     sh_in <= byte_in[7-LANES:0];
                     if (bcnt == LAST) begin
                        bcnt        <= '0;
                        csr_address <= byte_in[ADDR_W-1:0];
                        if (byte_in[HDR_RW_BIT]) begin
                           state <= S_WDATA;
                        end else begin
                           csr_read <= 1'b1;
                           pvalid   <= 1'b0;
                           dcnt     <= '0;
                           ocnt     <= '0;
                           state    <= (DUMMY == 0) ? S_RDATA
                                                    : S_DUMMY;
                        end
                     end else begin
                        bcnt <= bcnt + 3'd1;
                     end
                  end
               end
               S_WDATA: begin
                  if (sck_rise) begin
                     sh_in <= byte_in[7-LANES:0];
                     if (bcnt == LAST) begin
                        bcnt          <= '0;
                        csr_write     <= 1'b1;
                        csr_writedata <= byte_in;
                     end else begin
                        bcnt <= bcnt + 3'd1;
                     end
                  end
               end
               S_DUMMY: begin
                  if (sck_fall) begin
                     dcnt <= dcnt + 4'd1;
                     if (dcnt == DLAST) state <= S_RDATA;
                  end
               end
               S_RDATA: begin
                  if (sck_fall) begin
                     sdio_oe <= lane_mask(LANES);
                     ocnt    <= (ocnt == LAST) ? 3'd0 : ocnt + 3'd1;
                     if (ocnt == 3'd0) begin
                        // Word boundary: consume prefetch, fetch next.
                        if (!pvalid) overrun <= 1'b1;
                        sdio_o      <= place(pbuf[7 -: LANES]);
                        out_sh      <= pbuf << LANES;
                        pvalid      <= 1'b0;
                        csr_address <= csr_address + INC;
                        csr_read    <= 1'b1;
                     end else begin
                        sdio_o <= place(out_sh[7 -: LANES]);
                        out_sh <= out_sh << LANES;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
